cdce_spi_responder: RTL and testbench
=====================================

# cdce_spi_responder

Synchronous SPI responder for the CDCE62005-style 32-bit, LSB-first, latch-enable-framed serial protocol. It captures write frames into a 9-entry shadow register file, recognises EEPROM-store commands, and answers read commands by shifting the addressed register out on MISO during the following frame. It sits on the FPGA side of the clock-chip SPI bus, either as a board-level stand-in for the clock synthesiser or as a configuration mirror inspected by the host logic.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth on spi_clk/spi_mosi/spi_le (legal 2..3).
- NUM_REGS, 9: implemented register addresses 0..NUM_REGS-1 (max 14).

Ports:
- clk  in  1  system clock; must be ≥ 4× SPI clock frequency.
- rst_n  in  1  asynchronous, active-low reset.
- spi_clk  in  1  SPI clock from master; idle low.
- spi_mosi  in  1  serial data, sampled on spi_clk rising edge.
- spi_le  in  1  latch enable; low during a frame, rising edge commits.
- spi_miso  out  1  readback data, updated after spi_clk falling edge.
- wr_valid  out  1  one-cycle pulse: a register write was committed.
- wr_addr  out  4  address of the committed write.
- wr_data  out  28  data bits [31:4] of the committed write.
- eeprom_store  out  1  one-cycle pulse on a committed word 32'h0000001F.
- frame_err  out  1  one-cycle pulse: frame closed with bit count ≠ 32.
- host_addr  in  4  host-side register read address.
- host_data  out  32  registered contents of host_addr (full word incl. address nibble).

## Operation
- Inputs pass through SYNC_STAGES flops, then one edge-detect flop; all logic acts on detected edges.
- Word format: bits[3:0] address, bits[31:4] data; bit 0 arrives first.
- States: WAIT_IDLE → IDLE → SHIFT → COMMIT → IDLE.
  - WAIT_IDLE: entered from reset; leaves only when synchronised spi_le is high (frame in progress at reset release is ignored).
  - IDLE: on spi_le falling edge, clear bit counter, load readback shifter, go SHIFT.
  - SHIFT: each spi_clk rising edge shifts spi_mosi into bit 31 of the capture register (shift right), counter saturates at 33. spi_le rising edge → COMMIT.
  - COMMIT (one cycle): decode, then IDLE.
- Decode when count = 32:
  - Low nibble = 4'hE and bits[31:8] = 0: read command; latch pending address bits[7:4]; no register write.
  - Address 4'hF: no register write; eeprom_store pulses if the word is 32'h0000001F.
  - Address < NUM_REGS: store full 32-bit word; wr_valid/wr_addr/wr_data pulse.
  - Other addresses: discarded silently.
- Count ≠ 32: word discarded, frame_err pulses, pending read cleared.
- Register file resets to 32'h0. host_data = reg[host_addr], 0 for unimplemented addresses.

## Timing
- Reset values: spi_miso 0, wr_valid 0, wr_addr 0, wr_data 0, eeprom_store 0, frame_err 0, host_data 0, state WAIT_IDLE, pending read cleared.
- Pin-to-detect latency: SYNC_STAGES+1 clk cycles.
- wr_valid/eeprom_store/frame_err asserted in the single COMMIT cycle, SYNC_STAGES+2 cycles after spi_le rises on the pin.
- host_data latency 1 clk; a write committed in cycle N is visible on host_data at N+1 for a matching host_addr.
- Readback: on frame start bit 0 is on spi_miso within SYNC_STAGES+2 clk of spi_le falling, before the first rising spi_clk; each detected spi_clk falling edge advances one bit; after 32 bits spi_miso holds 0.
- spi_clk rising edge and spi_le rising edge detected in the same cycle: bit is shifted first, then COMMIT.
- spi_le falling edge during COMMIT is impossible (requires ≥1 cycle high at 4× ratio); not handled.
- rst_n assertion mid-frame aborts it: no pulses, pending read lost.

## Configuration
- CDCE_RESP_READBACK_EN defined: read commands latch a pending address; the next frame shifts reg[addr] (0 if unimplemented) out on spi_miso; the pending flag clears at that frame's start.
- Not defined: read-command words are discarded like unimplemented addresses, readback shifter absent, spi_miso tied 0.

## Test plan
- Write 32'h81400320 (LSB first, 32 clocks, LE high) → wr_valid one cycle, wr_addr 0, wr_data 28'h8140032; host_addr 0 → host_data 32'h81400320.
- Write 32'h0000001F → eeprom_store pulses once; no wr_valid; registers unchanged.
- Frame with 31 clocks, then 33 clocks → frame_err pulse each; register file unchanged.
- With CDCE_RESP_READBACK_EN: write reg5 = 32'hD0000B35, send 32'h0000005E, then 32 dummy clocks → spi_miso sampled on rising edges yields 32'hD0000B35 LSB first; without macro → all 0.
- Assert rst_n low after 16 bits with LE low, release with LE still low, finish 16 bits and raise LE → no pulses; next full frame commits normally.

Source files
------------

// File: rtl/cdce_spi_responder.sv
// SPI responder for the CDCE62005-style 32-bit LSB-first latch-enable-framed bus.
// Readback of registers on spi_miso is built only when CDCE_RESP_READBACK_EN is defined.
module cdce_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_le,
  output logic        spi_miso,
  output logic        wr_valid,
  output logic [3:0]  wr_addr,
  output logic [27:0] wr_data,
  output logic        eeprom_store,
  output logic        frame_err,
  input  logic [3:0]  host_addr,
  output logic [31:0] host_data
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

  localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);
  localparam int         TOP        = SYNC_STAGES - 1;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] clk_sync, mosi_sync, le_sync;
  logic                   clk_lvl, le_lvl;
  logic                   clk_rise, le_rise, le_fall;
  logic                   mosi_bit;

  logic [31:0] cap;
  logic [5:0]  bit_cnt;
  logic [31:0] regs [NUM_REGS];
  logic [31:0] host_sel;

  logic full, is_read, is_commit, do_write;

  // Synchronisers, then one level flop per line; edge strobes are registered so
  // they line up with mosi_bit, which carries the same delay.
  // NOTE: every clocked process uses non-blocking assignments so that all flops
  // sample pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '0;
      mosi_sync <= '0;
      le_sync   <= '0;
      clk_lvl   <= 1'b0;
      le_lvl    <= 1'b0;
      clk_rise  <= 1'b0;
      le_rise   <= 1'b0;
      le_fall   <= 1'b0;
      mosi_bit  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      le_sync   <= {le_sync[SYNC_STAGES-2:0], spi_le};
      clk_lvl   <= clk_sync[TOP];
      le_lvl    <= le_sync[TOP];
      clk_rise  <= clk_sync[TOP] & ~clk_lvl;
      le_rise   <= le_sync[TOP] & ~le_lvl;
      le_fall   <= ~le_sync[TOP] & le_lvl;
      mosi_bit  <= mosi_sync[TOP];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (le_lvl) state_nxt = IDLE;
      IDLE:      if (le_fall) state_nxt = SHIFT;
      SHIFT:     if (le_rise) state_nxt = COMMIT;
      COMMIT:    state_nxt = IDLE;
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  // Capture shifts right so the first (LSB) bit ends up in cap[0] after 32 clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap     <= '0;
      bit_cnt <= '0;
    end else if (state == IDLE && le_fall) begin
      bit_cnt <= '0;
    end else if (state == SHIFT && clk_rise) begin
      cap <= {mosi_bit, cap[31:1]};
      if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
    end
  end

  assign is_commit = (state == COMMIT);
  assign full      = (bit_cnt == 6'd32);
`ifdef CDCE_RESP_READBACK_EN
  assign is_read   = (cap[3:0] == 4'hE) && (cap[31:8] == 24'h0);
`else
  assign is_read   = 1'b0;
`endif
  assign do_write  = is_commit && full && !is_read && (cap[3:0] != 4'hF) &&
                     ({1'b0, cap[3:0]} < NUM_REGS_W);

  assign wr_valid     = do_write;
  assign wr_addr      = do_write ? cap[3:0] : 4'h0;
  assign wr_data      = do_write ? cap[31:4] : 28'h0;
  assign eeprom_store = is_commit && full && (cap == 32'h0000_001F);
  assign frame_err    = is_commit && !full;

  // NOTE: the register file is small and must read back as zero after reset,
  // so it is reset explicitly rather than left to RAM inference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (do_write) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (cap[3:0] == 4'(i)) regs[i] <= cap;
    end
  end

  always_comb begin
    host_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (host_addr == 4'(i)) host_sel = regs[i];
  end

  // Bypass makes a write committed this cycle visible on host_data next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 host_data <= '0;
    else if (do_write && cap[3:0] == host_addr) host_data <= cap;
    else                                        host_data <= host_sel;
  end

`ifdef CDCE_RESP_READBACK_EN
  logic        clk_fall;
  logic        pend_vld;
  logic [3:0]  pend_addr;
  logic [31:0] rd_shift;
  logic [31:0] rb_sel;

  always_comb begin
    rb_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (pend_addr == 4'(i)) rb_sel = regs[i];
  end

  // The register is sampled at frame start; zeros shift in behind the data so
  // spi_miso settles to 0 once all 32 bits are out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_fall  <= 1'b0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      rd_shift  <= '0;
      spi_miso  <= 1'b0;
    end else begin
      clk_fall <= ~clk_sync[TOP] & clk_lvl;
      if (state == IDLE && le_fall) begin
        rd_shift <= pend_vld ? rb_sel : 32'h0;
        spi_miso <= pend_vld ? rb_sel[0] : 1'b0;
        pend_vld <= 1'b0;
      end else if (state == SHIFT && clk_fall) begin
        rd_shift <= {1'b0, rd_shift[31:1]};
        spi_miso <= rd_shift[1];
      end
      if (is_commit && full && is_read) begin
        pend_vld  <= 1'b1;
        pend_addr <= cap[7:4];
      end else if (is_commit && !full) begin
        pend_vld <= 1'b0;
      end
    end
  end
`else
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_cdce_spi_responder.sv
// Scoreboard bench for cdce_spi_responder: stimulus queues expected commit events,
// a negedge monitor pops and compares them; host_data and readback are checked inline.
module tb_cdce_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_le = 1'b1;
  logic [3:0]  host_addr = 4'h0;
  logic        spi_miso;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [27:0] wr_data;
  logic        eeprom_store;
  logic        frame_err;
  logic [31:0] host_data;

  typedef struct packed {
    logic [2:0]  kind;   // {frame_err, eeprom_store, wr_valid}
    logic [3:0]  addr;
    logic [27:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  cdce_spi_responder #(.SYNC_STAGES(2), .NUM_REGS(9)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_le(spi_le), .spi_miso(spi_miso), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .eeprom_store(eeprom_store),
    .frame_err(frame_err), .host_addr(host_addr), .host_data(host_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input logic [2:0] kind, input logic [3:0] addr, input logic [27:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: any pulse cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (wr_valid || eeprom_store || frame_err)) begin
      ev_t act;
      ev_t exp;
      act.kind = {frame_err, eeprom_store, wr_valid};
      act.addr = wr_addr;
      act.data = wr_data;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got %h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        check("commit_event", 64'(act), 64'(exp));
      end
    end
  end

  task automatic spi_bit(input logic b, inout logic [31:0] rb, input int idx);
    spi_mosi = b;
    wait_clk(4);
    spi_clk = 1'b1;
    if (idx < 32) rb[idx] = spi_miso;
    wait_clk(4);
    spi_clk = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits, output logic [31:0] rb);
    logic [31:0] r;
    r = '0;
    spi_le = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) spi_bit((i < 32) ? word[i] : 1'b0, r, i);
    wait_clk(4);
    spi_le = 1'b1;
    wait_clk(12);
    rb = r;
  endtask

  task automatic check_host(input string name, input logic [3:0] a, input logic [31:0] exp);
    host_addr = a;
    wait_clk(2);
    check(name, 64'(host_data), 64'(exp));
  endtask

  initial begin
    logic [31:0] rb;
    logic [31:0] exp_rb;
    logic [31:0] w;

    wait_clk(3);
    check("rst_spi_miso",     64'(spi_miso),     64'd0);
    check("rst_wr_valid",     64'(wr_valid),     64'd0);
    check("rst_wr_addr",      64'(wr_addr),      64'd0);
    check("rst_wr_data",      64'(wr_data),      64'd0);
    check("rst_eeprom_store", 64'(eeprom_store), 64'd0);
    check("rst_frame_err",    64'(frame_err),    64'd0);
    check("rst_host_data",    64'(host_data),    64'd0);
    rst_n = 1'b1;
    wait_clk(8);

    push_ev(3'b001, 4'h0, 28'h8140032);
    send_frame(32'h8140_0320, 32, rb);
    check_host("host_reg0_write", 4'h0, 32'h8140_0320);

    push_ev(3'b010, 4'h0, 28'h0);
    send_frame(32'h0000_001F, 32, rb);
    check_host("host_reg0_after_eeprom", 4'h0, 32'h8140_0320);
    check_host("host_addr15_zero", 4'hF, 32'h0);

    push_ev(3'b100, 4'h0, 28'h0);
    send_frame(32'h1234_5671, 31, rb);
    push_ev(3'b100, 4'h0, 28'h0);
    send_frame(32'h1234_5671, 33, rb);
    check_host("host_reg1_after_bad_frames", 4'h1, 32'h0);
    check_host("host_reg0_after_bad_frames", 4'h0, 32'h8140_0320);

    send_frame(32'h1234_5679, 32, rb);
    check_host("host_unimpl_addr9", 4'h9, 32'h0);

    push_ev(3'b001, 4'h5, 28'hD0000B3);
    send_frame(32'hD000_0B35, 32, rb);
    check_host("host_reg5_write", 4'h5, 32'hD000_0B35);
    send_frame(32'h0000_005E, 32, rb);
    send_frame(32'hFFFF_FFFF, 32, rb);
`ifdef CDCE_RESP_READBACK_EN
    exp_rb = 32'hD000_0B35;
`else
    exp_rb = 32'h0;
`endif
    check("miso_readback", 64'(rb), 64'(exp_rb));
    check("miso_idle_after_frame", 64'(spi_miso), 64'd0);

    // Reset mid-frame: the tail of the frame must not commit anything.
    w = 32'hA5A5_A5A3;
    rb = '0;
    spi_le = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 16; i++) spi_bit(w[i], rb, i);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    for (int i = 16; i < 32; i++) spi_bit(w[i], rb, i);
    wait_clk(4);
    spi_le = 1'b1;
    wait_clk(12);
    check_host("host_reg5_after_reset", 4'h5, 32'h0);

    push_ev(3'b001, 4'h3, 28'hA5A5A5A);
    send_frame(32'hA5A5_A5A3, 32, rb);
    check_host("host_reg3_after_reset_frame", 4'h3, 32'hA5A5_A5A3);

    wait_clk(20);
    check("events_outstanding", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
